// File: rtl/program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer_if
// Brief    : Fetch/execute bus bundle between the sequencer and RAM/controller.
// Revision : 1.0
// ============================================================================
interface program_sequencer_if #(
    parameter int AW = 10
);
    logic [9:0]    bus_in;
    logic          exec_done;
    logic [AW-1:0] pc_bus;
    logic          pc_oe;
    logic          ar_load;
    logic          ram_rd;
    logic          ir_load;
    logic          exec_go;

    modport master (
        input  bus_in, exec_done,
        output pc_bus, pc_oe, ar_load, ram_rd, ir_load, exec_go
    );

    modport slave (
        output bus_in, exec_done,
        input  pc_bus, pc_oe, ar_load, ram_rd, ir_load, exec_go
    );
endinterface
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : PC fetch/execute sequencer; optional breakpoint via
//            PROGRAM_SEQUENCER_BREAKPOINT_EN.
// Revision : 1.0
// ============================================================================
module program_sequencer #(
    parameter int         AW       = 10,
    parameter logic [1:0] HALT_OP  = 2'b01,
    parameter int         WDOG_MAX = 8
) (
    input  logic              CLKb,
    input  logic              CLRn,
    input  logic              run,
    input  logic              step,
    input  logic              stop,
    input  logic [AW-1:0]     start_addr,
`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
    input  logic              brk_en,
    input  logic [AW-1:0]     brk_addr,
    output logic              brk_hit,
`endif
    program_sequencer_if.master bus,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [AW-1:0]     pc,
    output logic [15:0]       retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [7:0] c_WDOG_LAST = 8'(WDOG_MAX - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_retired;
    logic [7:0]    r_wdog;
    logic          r_stop;
    logic          r_single;

    logic w_halt_word;
    logic w_end;
    logic w_brk;
    logic w_bus_unused;

    assign w_halt_word  = (bus.bus_in[9:8] == HALT_OP);
    // A stop arriving in the very cycle of exec_done still ends the run here.
    assign w_end        = r_single | r_stop | stop;
    assign w_bus_unused = &{1'b0, bus.bus_in[7:0]};

`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
    logic r_brk_hit;

    assign w_brk   = brk_en && (r_pc == brk_addr);
    assign brk_hit = r_brk_hit;

    always_ff @(posedge CLKb or negedge CLRn) begin
        if (!CLRn) begin
            r_brk_hit <= 1'b0;
        end else begin
            r_brk_hit <= (r_state == S_EXEC) && bus.exec_done && !w_end && w_brk;
        end
    end
`else
    assign w_brk = 1'b0;
`endif

    always_ff @(posedge CLKb or negedge CLRn) begin
        if (!CLRn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run || step) w_next = S_ADDR;
            S_ADDR:   w_next = S_READ;
            S_READ:   w_next = w_halt_word ? S_HALTED : S_EXEC;
            S_EXEC: begin
                if (bus.exec_done) begin
                    w_next = (w_end || w_brk) ? S_IDLE : S_ADDR;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_next = S_FAULT;
                end
            end
            S_HALTED, S_FAULT: if (run) w_next = S_ADDR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLKb or negedge CLRn) begin
        if (!CLRn) begin
            r_pc      <= '0;
            r_retired <= '0;
            r_wdog    <= '0;
            r_stop    <= 1'b0;
            r_single  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_pc     <= start_addr;
                        r_single <= 1'b0;
                        r_stop   <= 1'b0;
                    end else if (step) begin
                        r_single <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (stop) r_stop <= 1'b1;
                end
                S_READ: begin
                    if (stop) r_stop <= 1'b1;
                    if (!w_halt_word) begin
                        r_pc   <= r_pc + AW'(1);
                        r_wdog <= '0;
                    end
                end
                S_EXEC: begin
                    r_wdog <= r_wdog + 8'd1;
                    if (bus.exec_done) r_retired <= r_retired + 16'd1;
                    if (bus.exec_done && w_end) begin
                        r_single <= 1'b0;
                        r_stop   <= 1'b0;
                    end else if (stop) begin
                        r_stop <= 1'b1;
                    end
                end
                S_HALTED, S_FAULT: begin
                    // A fresh run never inherits step/stop intent from before the halt.
                    if (run) begin
                        r_pc     <= start_addr;
                        r_single <= 1'b0;
                        r_stop   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.pc_bus  = '0;
        bus.pc_oe   = 1'b0;
        bus.ar_load = 1'b0;
        bus.ram_rd  = 1'b0;
        bus.ir_load = 1'b0;
        bus.exec_go = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (r_state)
            S_ADDR: begin
                bus.pc_bus  = r_pc;
                bus.pc_oe   = 1'b1;
                bus.ar_load = 1'b1;
                busy        = 1'b1;
            end
            S_READ: begin
                bus.ram_rd  = 1'b1;
                bus.ir_load = 1'b1;
                busy        = 1'b1;
            end
            S_EXEC: begin
                bus.exec_go = 1'b1;
                busy        = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default: begin
            end
        endcase
    end

    assign pc      = r_pc;
    assign retired = r_retired;

endmodule
`default_nettype wire
